// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: packet-level round-robin mux of NREQ AXI-stream sources onto the
// single register-sliced USB TX stream (32b data, tkeep, tlast).
module usb_tx_arbiter #(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      s_tvalid,
  output logic [NREQ-1:0]      s_tready,
  input  logic [NREQ*32-1:0]   s_tdata,
  input  logic [NREQ*4-1:0]    s_tkeep,
  input  logic [NREQ-1:0]      s_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [31:0]          m_tdata,
  output logic [3:0]           m_tkeep,
  output logic                 m_tlast,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic [CNT_W-1:0]     pkt_cnt
);

  localparam int IDX_W = (NREQ > 2) ? 2 : 1;
  localparam logic [NREQ-1:0]  GRANT_ONE   = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LAST_RESET  = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [NREQ-1:0]  grant_r;
  logic [NREQ-1:0]  grant_nxt_s;
  logic [IDX_W-1:0] gidx_r;
  logic [IDX_W-1:0] gidx_nxt_s;
  logic [IDX_W-1:0] last_idx_r;
  logic [IDX_W-1:0] last_idx_nxt_s;

  logic             m_tvalid_r;
  logic [31:0]      m_tdata_r;
  logic [3:0]       m_tkeep_r;
  logic             m_tlast_r;
  logic [CNT_W-1:0] pkt_cnt_r;

  logic [IDX_W-1:0] pick_s;
  logic             pick_ok_s;
  logic             sel_valid_s;
  logic             sel_last_s;
  logic [31:0]      sel_data_s;
  logic [3:0]       sel_keep_s;
  logic             out_free_s;
  logic             load_s;
  logic             pkt_end_s;
  logic [NREQ-1:0]  s_tready_s;
  logic             busy_s;

  // Round-robin scan: first valid source after the last one that finished a packet
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             take;
    cand      = 0;
    cand_idx  = {IDX_W{1'b0}};
    take      = 1'b0;
    pick_ok_s = 1'b0;
    pick_s    = last_idx_r;
    for (int k = 1; k <= NREQ; k++) begin
      cand      = int'(last_idx_r) + k;
      cand      = (cand >= NREQ) ? cand - NREQ : cand;
      cand_idx  = IDX_W'(cand);
      take      = ~pick_ok_s & s_tvalid[cand_idx];
      pick_s    = take ? cand_idx : pick_s;
      pick_ok_s = pick_ok_s | take;
    end
  end

  // One-hot grant selects the active source's beat
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = 32'h0000_0000;
    sel_keep_s  = 4'h0;
    for (int i = 0; i < NREQ; i++) begin
      sel_valid_s = sel_valid_s | (s_tvalid[i] & grant_r[i]);
      sel_last_s  = sel_last_s  | (s_tlast[i]  & grant_r[i]);
      sel_data_s  = sel_data_s  | (s_tdata[i*32 +: 32] & {32{grant_r[i]}});
      sel_keep_s  = sel_keep_s  | (s_tkeep[i*4 +: 4]   & {4{grant_r[i]}});
    end
  end

  assign out_free_s = ~m_tvalid_r | m_tready;
  assign load_s     = (state_r == ST_BUSY) & sel_valid_s & out_free_s;
  assign pkt_end_s  = load_s & sel_last_s;

  // FSM state and grant bookkeeping registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      grant_r    <= {NREQ{1'b0}};
      gidx_r     <= {IDX_W{1'b0}};
      last_idx_r <= LAST_RESET;
    end else begin
      state_r    <= state_nxt_s;
      grant_r    <= grant_nxt_s;
      gidx_r     <= gidx_nxt_s;
      last_idx_r <= last_idx_nxt_s;
    end
  end

  // FSM next state: grant in IDLE, release on the accepted tlast beat
  always_comb begin
    state_nxt_s    = state_r;
    grant_nxt_s    = grant_r;
    gidx_nxt_s     = gidx_r;
    last_idx_nxt_s = last_idx_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_ok_s) begin
          state_nxt_s = ST_BUSY;
          grant_nxt_s = GRANT_ONE << pick_s;
          gidx_nxt_s  = pick_s;
        end else begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = {NREQ{1'b0}};
        end
      end
      ST_BUSY: begin
        if (pkt_end_s) begin
          state_nxt_s    = ST_IDLE;
          grant_nxt_s    = {NREQ{1'b0}};
          last_idx_nxt_s = gidx_r;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = {NREQ{1'b0}};
      end
    endcase
  end

  // FSM outputs: only the granted source sees ready, and only while the slice can take a beat
  always_comb begin
    busy_s     = 1'b0;
    s_tready_s = {NREQ{1'b0}};
    case (state_r)
      ST_IDLE: begin
        busy_s     = 1'b0;
        s_tready_s = {NREQ{1'b0}};
      end
      ST_BUSY: begin
        busy_s     = 1'b1;
        s_tready_s = grant_r & {NREQ{out_free_s}};
      end
      default: begin
        busy_s     = 1'b0;
        s_tready_s = {NREQ{1'b0}};
      end
    endcase
  end

  // Output register slice; holds its beat while stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_tvalid_r <= 1'b0;
      m_tdata_r  <= 32'h0000_0000;
      m_tkeep_r  <= 4'h0;
      m_tlast_r  <= 1'b0;
    end else if (load_s) begin
      m_tvalid_r <= 1'b1;
      m_tdata_r  <= sel_data_s;
      m_tkeep_r  <= sel_keep_s;
      m_tlast_r  <= sel_last_s;
    end else if (m_tready) begin
      m_tvalid_r <= 1'b0;
    end
  end

  // Completed-packet counter, wraps naturally
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt_r <= {CNT_W{1'b0}};
    end else if (m_tvalid_r & m_tready & m_tlast_r) begin
      pkt_cnt_r <= pkt_cnt_r + CNT_ONE;
    end
  end

  assign s_tready = s_tready_s;
  assign busy     = busy_s;
  assign grant    = grant_r;
  assign m_tvalid = m_tvalid_r;
  assign m_tdata  = m_tdata_r;
  assign m_tkeep  = m_tkeep_r;
  assign m_tlast  = m_tlast_r;
  assign pkt_cnt  = pkt_cnt_r;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Scoreboard bench for usb_tx_arbiter: source drivers feed per-source beat queues,
// expected beats are queued in hand-derived arbitration order and checked by a monitor.
module tb_usb_tx_arbiter;

  logic        clk;
  logic        rstn;
  logic [1:0]  s_tvalid;
  logic [1:0]  s_tready;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic [1:0]  s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic [1:0]  grant;
  logic        busy;
  logic [3:0]  pkt_cnt;

  usb_tx_arbiter #(.NREQ(2), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .grant(grant), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_chk  = 0;
  logic [36:0] q0[$];
  logic [36:0] q1[$];
  logic [36:0] exp_q[$];
  logic hs0 = 1'b0;
  logic hs1 = 1'b0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // beat = {last, keep, data}; data tags source, packet id and beat index
  function automatic logic [36:0] mk(input int src, input int id, input int i, input int n,
                                     input logic [3:0] kl);
    logic [31:0] d;
    logic        l;
    d = 32'h5000_0000 + 32'(src) * 32'h0100_0000 + 32'(id) * 32'h0000_0100 + 32'(i);
    l = (i == n - 1);
    return {l, (l ? kl : 4'hF), d};
  endfunction

  task automatic add_pkt(input int src, input int id, input int n, input logic [3:0] kl);
    for (int i = 0; i < n; i++) begin
      if (src == 0) q0.push_back(mk(src, id, i, n, kl));
      else          q1.push_back(mk(src, id, i, n, kl));
    end
  endtask

  task automatic exp_pkt(input int src, input int id, input int n, input logic [3:0] kl);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(src, id, i, n, kl));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 || m_tvalid) && t < budget) begin
      @(negedge clk); #2;
      t++;
    end
    if (t >= budget)
      $display("FAIL %s: timeout, %0d beats still expected", name, exp_q.size());
    chk({name, "_done"}, 64'(t < budget), 64'd1);
    @(negedge clk); #2;
  endtask

  // Source / sink driver: present queue heads at negedge, note handshakes before the posedge
  initial begin
    logic [36:0] b0;
    logic [36:0] b1;
    logic [36:0] tmp;
    int cyc;
    cyc = 0;
    s_tvalid = 2'b00; s_tdata = 64'h0; s_tkeep = 8'h0; s_tlast = 2'b00; m_tready = 1'b0;
    forever begin
      @(negedge clk);
      if (hs0 && q0.size() != 0) tmp = q0.pop_front();
      if (hs1 && q1.size() != 0) tmp = q1.pop_front();
      b0 = (q0.size() != 0) ? q0[0] : 37'h0;
      b1 = (q1.size() != 0) ? q1[0] : 37'h0;
      s_tvalid = {q1.size() != 0, q0.size() != 0};
      s_tdata  = {b1[31:0], b0[31:0]};
      s_tkeep  = {b1[35:32], b0[35:32]};
      s_tlast  = {b1[36], b0[36]};
      m_tready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      cyc++;
      #1;
      hs0 = s_tvalid[0] & s_tready[0];
      hs1 = s_tvalid[1] & s_tready[1];
    end
  end

  // Monitor: compares every output handshake with the scoreboard and checks stall rules
  initial begin
    logic        prev_stall;
    logic [37:0] prev_m;
    logic [37:0] cur;
    logic [36:0] e;
    prev_stall = 1'b0;
    prev_m     = 38'h0;
    forever begin
      @(negedge clk); #1;
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        cur = {m_tvalid, m_tlast, m_tkeep, m_tdata};
        if (prev_stall) chk("m_stable", 64'(cur), 64'(prev_m));
        if (m_tvalid && !m_tready) begin
          chk("s_tready_stall", 64'(s_tready), 64'd0);
          prev_stall = 1'b1;
          prev_m     = cur;
        end else begin
          prev_stall = 1'b0;
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL beat_unexpected: got 0x%0h expected none", cur[36:0]);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 64'(cur[36:0]), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    logic [1:0] trace[$];
    int n01, n10, last01, first10, first_nz, t;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_data", 64'({m_tlast, m_tkeep, m_tdata}), 64'd0);
    rstn = 1'b1;
    @(negedge clk); #2;

    // both sources request 3-beat packets at once: src0 first, then src1
    add_pkt(0, 1, 3, 4'h7);
    add_pkt(1, 2, 3, 4'h3);
    exp_pkt(0, 1, 3, 4'h7);
    exp_pkt(1, 2, 3, 4'h3);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk); #2;
      trace.push_back(grant);
    end
    n01 = 0; n10 = 0; last01 = -1; first10 = -1; first_nz = -1;
    for (int i = 0; i < trace.size(); i++) begin
      if (trace[i] != 2'b00 && first_nz < 0) first_nz = i;
      if (trace[i] == 2'b01) begin n01++; last01 = i; end
      if (trace[i] == 2'b10) begin n10++; if (first10 < 0) first10 = i; end
    end
    chk("t1_first_grant", 64'((first_nz >= 0) ? trace[first_nz] : 2'b00), 64'h1);
    chk("t1_cycles_g01", 64'(n01), 64'd3);
    chk("t1_cycles_g10", 64'(n10), 64'd3);
    chk("t1_idle_gap", 64'(first10 - last01 - 1), 64'd1);
    wait_idle("t1", 200);
    chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd2);
    chk("t1_busy_idle", 64'(busy), 64'd0);

    // src0 back-to-back 2-beat packets, src1 waiting: packets alternate, one with tkeep=0 last
    add_pkt(0, 10, 2, 4'hF); add_pkt(0, 11, 2, 4'h7); add_pkt(0, 12, 2, 4'hE);
    add_pkt(1, 20, 2, 4'h0); add_pkt(1, 21, 2, 4'hC);
    exp_pkt(0, 10, 2, 4'hF); exp_pkt(1, 20, 2, 4'h0);
    exp_pkt(0, 11, 2, 4'h7); exp_pkt(1, 21, 2, 4'hC);
    exp_pkt(0, 12, 2, 4'hE);
    wait_idle("t2", 300);
    chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd7);

    // 5-beat packet under m_tready pattern 1,0,0
    rdy_mode = 1;
    add_pkt(0, 30, 5, 4'h8);
    exp_pkt(0, 30, 5, 4'h8);
    wait_idle("t3", 300);
    rdy_mode = 0;
    chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd8);

    // single beat: visible one cycle after acceptance, state back to IDLE
    q0.push_back({1'b1, 4'b0011, 32'hA5A5_A5A5});
    exp_q.push_back({1'b1, 4'b0011, 32'hA5A5_A5A5});
    t = 0;
    while (!(busy && hs0) && t < 40) begin
      @(negedge clk); #2;
      t++;
    end
    chk("t4_accept_seen", 64'(t < 40), 64'd1);
    @(negedge clk); #2;
    chk("t4_m_tvalid", 64'(m_tvalid), 64'd1);
    chk("t4_m_beat", 64'({m_tlast, m_tkeep, m_tdata}), 64'({1'b1, 4'b0011, 32'hA5A5_A5A5}));
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_grant", 64'(grant), 64'd0);
    wait_idle("t4", 100);
    chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd9);

    // asynchronous reset while beat 2 of 4 is moving
    add_pkt(0, 40, 4, 4'hF);
    exp_pkt(0, 40, 4, 4'hF);
    t = 0;
    while (exp_q.size() > 3 && t < 60) begin
      @(negedge clk); #2;
      t++;
    end
    chk("t5_reach_beat2", 64'(t < 60), 64'd1);
    rstn = 1'b0;
    q0.delete(); q1.delete(); exp_q.delete();
    hs0 = 1'b0; hs1 = 1'b0;
    #1;
    chk("t5_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("t5_grant", 64'(grant), 64'd0);
    chk("t5_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("t5_m_data", 64'({m_tlast, m_tkeep, m_tdata}), 64'd0);
    repeat (2) @(negedge clk);
    #2;
    rstn = 1'b1;
    add_pkt(1, 50, 2, 4'h3);
    exp_pkt(1, 50, 2, 4'h3);
    t = 0;
    while (grant == 2'b00 && t < 40) begin
      @(negedge clk); #2;
      t++;
    end
    chk("t5_src1_grant", 64'(grant), 64'h2);
    wait_idle("t5", 100);
    chk("t5_pkt_cnt_after", 64'(pkt_cnt), 64'd1);

    // counter wrap with 4-bit counter: 1 + 14 = 15, then +2 = 17 -> 1
    for (int p = 0; p < 7; p++) begin
      add_pkt(0, 60 + p, 1, 4'h1);
      add_pkt(1, 60 + p, 1, 4'h2);
      exp_pkt(0, 60 + p, 1, 4'h1);
      exp_pkt(1, 60 + p, 1, 4'h2);
    end
    wait_idle("t6a", 400);
    chk("t6_pkt_cnt_15", 64'(pkt_cnt), 64'd15);
    add_pkt(0, 70, 1, 4'h4);
    add_pkt(1, 70, 1, 4'h8);
    exp_pkt(0, 70, 1, 4'h4);
    exp_pkt(1, 70, 1, 4'h8);
    wait_idle("t6b", 100);
    chk("t6_pkt_cnt_wrap", 64'(pkt_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
